alu_operand_stage: RTL and testbench

Issue stage directly upstream of the ALU: reads two source registers from an 8×16 register file, selects register or immediate for operand B, and holds operands plus ALU opcode in a one-entry pipeline register with a valid/ready handshake. The ALU consumes `out_a`, `out_b` and `out_alu_op`. Results come back through the writeback port into the register file. A per-register pending scoreboard stalls issue on RAW and WAW hazards against writes not yet retired.

---
 rtl/alu_operand_stage_pkg.sv | 24 ++
 rtl/alu_operand_stage_reg_file.sv | 36 +++
 rtl/alu_operand_stage.sv | 126 ++++++++++++
 tb/tb_alu_operand_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand issue stage: ALU opcodes and
// register-file geometry.
package alu_operand_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int ALU_OP_W   = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
module reg_file
    import alu_operand_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: cleared on reset, single write port at the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: register 0 is forced to zero regardless of storage.
    always_comb begin
        rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand issue stage: register read, immediate select, pending-write
// scoreboard for RAW/WAW stalls, and a one-entry valid/ready output register.
// Optional feature macro: OPERAND_BYPASS_EN (same-cycle writeback masks the
// pending bit and forwards wb_data into the operands).
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [ALU_OP_W-1:0]   out_alu_op,
    output logic [REG_ADDR_W-1:0] out_rd,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] pend_view;
    logic [DATA_W-1:0]   rf_a;
    logic [DATA_W-1:0]   rf_b;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;
    logic                wb_hit;
    logic                haz;
    logic                accept;

    reg_file u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (in_rs),
        .rd_addr_b (in_rt),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

    assign wb_hit = wb_en && (wb_rd != REG_ZERO);

`ifdef OPERAND_BYPASS_EN
    logic [NUM_REGS-1:0] wb_mask;

    // A retiring write hides its own pending bit and supplies the operand.
    always_comb begin
        wb_mask = '0;
        if (wb_hit) begin
            wb_mask[wb_rd] = 1'b1;
        end
        pend_view = pend & ~wb_mask;
        opnd_a    = (wb_hit && (wb_rd == in_rs)) ? wb_data : rf_a;
        if (in_use_imm) begin
            opnd_b = in_imm;
        end else begin
            opnd_b = (wb_hit && (wb_rd == in_rt)) ? wb_data : rf_b;
        end
    end
`else
    // Without bypass the stall holds until the cycle after the writeback.
    always_comb begin
        pend_view = pend;
        opnd_a    = rf_a;
        opnd_b    = in_use_imm ? in_imm : rf_b;
    end
`endif

    // Hazard check and handshake; rt is irrelevant when the immediate is used.
    always_comb begin
        haz      = pend_view[in_rs] | (!in_use_imm & pend_view[in_rt]) | pend_view[in_rd];
        in_ready = !haz & (!out_valid | out_ready);
        accept   = in_valid & in_ready;
    end

    // Scoreboard update: writeback clears first, so a same-cycle issue set wins.
    always_comb begin
        pend_next = pend;
        if (wb_hit) begin
            pend_next[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != REG_ZERO)) begin
            pend_next[in_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Output entry: load on accept, drain on transfer, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_alu_op <= '0;
            out_rd     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_a      <= opnd_a;
            out_b      <= opnd_b;
            out_alu_op <= in_alu_op;
            out_rd     <= in_rd;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Inputs change just after the falling
// edge; registered and combinational outputs are sampled before the next
// rising edge.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs;
    logic [REG_ADDR_W-1:0] in_rt;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]     in_imm;
    logic                  in_use_imm;
    logic [ALU_OP_W-1:0]   in_alu_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_a;
    logic [DATA_W-1:0]     out_b;
    logic [ALU_OP_W-1:0]   out_alu_op;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;

    int vectors;
    int miscompares;

    alu_operand_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_alu_op  (in_alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_alu_op (out_alu_op),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full clock: cross the rising edge, return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                           input logic use_imm, input logic [15:0] imm, input logic [3:0] op);
        in_valid   = 1'b1;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_alu_op  = op;
    endtask

    task automatic writeback(input logic [2:0] rd, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic check_out(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] op, input logic [2:0] rd);
        check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".a"},     32'(out_a),     32'(a));
        check_val({tag, ".b"},     32'(out_b),     32'(b));
        check_val({tag, ".op"},    32'(out_alu_op), 32'(op));
        check_val({tag, ".rd"},    32'(out_rd),    32'(rd));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_rs      = '0;
        in_rt      = '0;
        in_rd      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        in_alu_op  = '0;
        out_ready  = 1'b1;
        wb_en      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check_val("rst.out_valid", 32'(out_valid), 32'd0);
        check_val("rst.out_a",     32'(out_a),     32'd0);
        check_val("rst.out_b",     32'(out_b),     32'd0);
        check_val("rst.out_op",    32'(out_alu_op), 32'd0);
        check_val("rst.out_rd",    32'(out_rd),    32'd0);
        check_val("rst.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);

        // Basic issue: R3=0x1234, R4=0x0010, ADD rs=3 rt=4 rd=5
        writeback(3'd3, 16'h1234);
        tick();
        writeback(3'd4, 16'h0010);
        tick();
        wb_en = 1'b0;
        present(3'd3, 3'd4, 3'd5, 1'b0, 16'h0000, ALU_ADD);
        #1 check_val("add.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("add", 16'h1234, 16'h0010, ALU_ADD, 3'd5);
        tick();
        check_val("add.drain", 32'(out_valid), 32'd0);

        // RAW on r5 with writeback 0xBEEF
        present(3'd5, 3'd4, 3'd6, 1'b0, 16'h0000, ALU_SUB);
        #1 check_val("raw.stall0", 32'(in_ready), 32'd0);
        tick();
        check_val("raw.stall1", 32'(in_ready), 32'd0);
        writeback(3'd5, 16'hBEEF);
`ifdef OPERAND_BYPASS_EN
        #1 check_val("raw.wb_cycle", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0;
`else
        #1 check_val("raw.wb_cycle", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        #1 check_val("raw.after_wb", 32'(in_ready), 32'd1);
        tick();
`endif
        in_valid = 1'b0;
        check_out("raw", 16'hBEEF, 16'h0010, ALU_SUB, 3'd6);
        writeback(3'd6, 16'h0006);
        tick();
        wb_en = 1'b0;

        // Backpressure: entry held for 3 cycles, next instruction waits
        out_ready = 1'b0;
        present(3'd3, 3'd4, 3'd1, 1'b0, 16'h0000, ALU_SUB);
        tick();
        present(3'd4, 3'd3, 3'd2, 1'b0, 16'h0000, ALU_OR);
        for (int i = 0; i < 3; i++) begin
            #1 check_val("bp.in_ready", 32'(in_ready), 32'd0);
            check_out("bp.hold", 16'h1234, 16'h0010, ALU_SUB, 3'd1);
            tick();
        end
        out_ready = 1'b1;
        #1 check_val("bp.release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("bp.next", 16'h0010, 16'h1234, ALU_OR, 3'd2);
        writeback(3'd1, 16'h1111);
        tick();
        check_val("bp.drain", 32'(out_valid), 32'd0);
        writeback(3'd2, 16'h2222);
        tick();
        wb_en = 1'b0;

        // Register 0: rd=0 sets nothing, write to r0 ignored
        present(3'd0, 3'd3, 3'd0, 1'b0, 16'h0000, ALU_AND);
        #1 check_val("r0.first_rdy", 32'(in_ready), 32'd1);
        tick();
        check_out("r0.first", 16'h0000, 16'h1234, ALU_AND, 3'd0);
        present(3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, ALU_XOR);
        writeback(3'd0, 16'hFFFF);
        #1 check_val("r0.no_stall", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0;
        check_out("r0.second", 16'h0000, 16'h0000, ALU_XOR, 3'd0);
        present(3'd0, 3'd1, 3'd0, 1'b0, 16'h0000, ALU_ADD);
        tick();
        in_valid = 1'b0;
        check_out("r0.after_wb", 16'h0000, 16'h1111, ALU_ADD, 3'd0);

        // Immediate: pending rt ignored when the immediate is selected
        present(3'd3, 3'd3, 3'd4, 1'b0, 16'h0000, ALU_XOR);
        tick();
        present(3'd3, 3'd4, 3'd6, 1'b0, 16'hFFF8, ALU_SLT);
        #1 check_val("imm.rt_pend", 32'(in_ready), 32'd0);
        in_use_imm = 1'b1;
        #1 check_val("imm.no_stall", 32'(in_ready), 32'd1);
        tick();
        in_valid   = 1'b0;
        in_use_imm = 1'b0;
        check_out("imm", 16'h1234, 16'hFFF8, ALU_SLT, 3'd6);
        tick();

        // WAW on r2 then reset while stalled
        present(3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, ALU_ADD);
        tick();
        check_out("waw.first", 16'h1234, 16'h1111, ALU_ADD, 3'd2);
        #1 check_val("waw.stall0", 32'(in_ready), 32'd0);
        tick();
        check_val("waw.stall1", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_val("waw.rst_valid", 32'(out_valid), 32'd0);
        check_val("waw.rst_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        present(3'd4, 3'd6, 3'd2, 1'b0, 16'h0000, ALU_OR);
        #1 check_val("rst.pend_clear", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        writeback(3'd2, 16'h5A5A);
        tick();
        wb_en = 1'b0;
        present(3'd2, 3'd3, 3'd7, 1'b0, 16'h0000, ALU_SRA);
        #1 check_val("rst.late_wb_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("rst.late_wb", 16'h5A5A, 16'h0000, ALU_SRA, 3'd7);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
